// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard stall generation.
// Latency: 1 cycle from ID inputs to registered outputs; stall_out is combinational.
// Backpressure: o_stall_out holds PC and IF/ID and a bubble is captured; flush overrides stall.
// Optional feature macro: ID_EX_FWD_EN (defined = forwarding, undefined = stall until the writer retires).
module id_ex_stage #(
  parameter int CTRL_W       = 16,
  parameter int REGWRITE_BIT = 0,
  parameter int MEMREAD_BIT  = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [63:0]       i_rd_data1,
  input  logic [63:0]       i_rd_data2,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [4:0]        i_rd_in,
  input  logic [63:0]       i_imm_in,
  input  logic [CTRL_W-1:0] i_ctrl_in,
  input  logic              i_valid_in,
  input  logic              i_flush,
  input  logic [63:0]       i_ex_result,
  input  logic [63:0]       i_mem_result,
  input  logic [4:0]        i_mem_rd,
  input  logic              i_mem_regwrite,
  input  logic [63:0]       i_wb_result,
  input  logic [4:0]        i_wb_rd,
  input  logic              i_wb_regwrite,
  output logic [63:0]       o_a_out,
  output logic [63:0]       o_b_out,
  output logic [63:0]       o_imm_out,
  output logic [4:0]        o_rd_out,
  output logic [CTRL_W-1:0] o_ctrl_out,
  output logic              o_valid_out,
  output logic              o_stall_out
);

  logic [63:0]       r_a;
  logic [63:0]       r_b;
  logic [63:0]       r_imm;
  logic [4:0]        r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;

  logic        w_ex_we;
  logic        w_ex_hit1, w_ex_hit2;
  logic        w_mem_hit1, w_mem_hit2;
  logic        w_wb_hit1, w_wb_hit2;
  logic        w_load_use;
  logic        w_hazard;
  logic [63:0] w_opnd_a;
  logic [63:0] w_opnd_b;

  // A writer hits a source when enabled, same register, and not the zero register X31.
  function automatic logic f_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst == src) && (dst != 5'd31);
  endfunction

  // The EX writer is the instruction currently held in this register.
  assign w_ex_we    = r_valid & r_ctrl[REGWRITE_BIT];
  assign w_ex_hit1  = f_hit(w_ex_we, r_rd, i_rs1);
  assign w_ex_hit2  = f_hit(w_ex_we, r_rd, i_rs2);
  assign w_mem_hit1 = f_hit(i_mem_regwrite, i_mem_rd, i_rs1);
  assign w_mem_hit2 = f_hit(i_mem_regwrite, i_mem_rd, i_rs2);
  assign w_wb_hit1  = f_hit(i_wb_regwrite, i_wb_rd, i_rs1);
  assign w_wb_hit2  = f_hit(i_wb_regwrite, i_wb_rd, i_rs2);

  // Load data is not ready until MEM, so a dependent instruction waits one cycle.
  // Built from registered state only: ex_result never reaches stall_out.
  assign w_load_use = i_valid_in & r_valid & r_ctrl[MEMREAD_BIT] &
                      (f_hit(1'b1, r_rd, i_rs1) | f_hit(1'b1, r_rd, i_rs2));

`ifdef ID_EX_FWD_EN
  // Youngest matching writer wins: EX, then MEM, then WB, then the register file.
  always_comb begin
    w_opnd_a = i_rd_data1;
    w_opnd_b = i_rd_data2;
    if (w_ex_hit1)       w_opnd_a = i_ex_result;
    else if (w_mem_hit1) w_opnd_a = i_mem_result;
    else if (w_wb_hit1)  w_opnd_a = i_wb_result;
    if (w_ex_hit2)       w_opnd_b = i_ex_result;
    else if (w_mem_hit2) w_opnd_b = i_mem_result;
    else if (w_wb_hit2)  w_opnd_b = i_wb_result;
  end

  assign w_hazard = w_load_use;
`else
  logic w_unused_results;

  // Without forwarding the operands come straight from the register file, and any
  // in-flight writer (including WB, written at the end of the cycle) holds the ID slot.
  assign w_opnd_a = i_rd_data1;
  assign w_opnd_b = i_rd_data2;
  assign w_hazard = (i_valid_in & (w_ex_hit1 | w_ex_hit2 | w_mem_hit1 | w_mem_hit2 |
                                   w_wb_hit1 | w_wb_hit2)) | w_load_use;
  assign w_unused_results = ^{i_ex_result, i_mem_result, i_wb_result};
`endif

  // A flushed instruction never stalls; reset also forces the stall low at once.
  assign o_stall_out = w_hazard & ~i_flush & ~i_reset;

  // Pipeline register: flush or stall inserts a bubble, otherwise capture the ID slot.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (i_flush || o_stall_out) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_a     <= w_opnd_a;
      r_b     <= w_opnd_b;
      r_imm   <= i_imm_in;
      r_rd    <= i_rd_in;
      r_ctrl  <= i_valid_in ? i_ctrl_in : '0;
      r_valid <= i_valid_in;
    end
  end

  assign o_a_out     = r_a;
  assign o_b_out     = r_b;
  assign o_imm_out   = r_imm;
  assign o_rd_out    = r_rd;
  assign o_ctrl_out  = r_ctrl;
  assign o_valid_out = r_valid;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for the 5-stage 64-bit CPU. It captures the two register-file read operands, immediate, destination and control bundle into the ID/EX pipeline register. It resolves read-after-write hazards by forwarding results from in-flight instructions, and it detects load-use hazards, stalling IF/ID and inserting a bubble. It sits between the register file's read ports and the ALU.

## Interface
- `CTRL_W`, default 16: width of the control bundle.
- `REGWRITE_BIT`, default 0: index in the control bundle of the register-write enable.
- `MEMREAD_BIT`, default 1: index in the control bundle of the load flag.
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rd_data1`, `rd_data2`  in  64  register file read data for rs1 and rs2.
- `rs1`, `rs2`  in  5  source register numbers (same values driven to the register file read selects).
- `rd_in`  in  5  destination register.
- `imm_in`  in  64  sign-extended immediate.
- `ctrl_in`  in  CTRL_W  decoded control bundle.
- `valid_in`  in  1  the ID slot holds a real instruction.
- `flush`  in  1  a taken branch kills the ID instruction.
- `ex_result`  in  64  the ALU output this cycle for the instruction held in this stage.
- `mem_result`, `mem_rd`, `mem_regwrite`  in  64/5/1  the EX/MEM stage writer.
- `wb_result`, `wb_rd`, `wb_regwrite`  in  64/5/1  the MEM/WB stage writer; same cycle as the register file write.
- `a_out`, `b_out`  out  64  registered operands.
- `imm_out`  out  64  registered immediate.
- `rd_out`  out  5  registered destination.
- `ctrl_out`  out  CTRL_W  registered control bundle.
- `valid_out`  out  1  registered valid.
- `stall_out`  out  1  combinational; holds PC and IF/ID when high.

## Operation
- The EX writer is the instruction currently held in this stage: its destination is `rd_out`, its result is `ex_result`, and it counts as a writer when `valid_out & ctrl_out[REGWRITE_BIT]`.
- A writer matches a source when its destination equals the source register, the destination is not 31, and its write enable is high.
- Operand select, evaluated separately for rs1 and rs2, in priority order:
  - EX match: `ex_result`.
  - Else MEM match: `mem_result`.
  - Else WB match: `wb_result`.
  - Else: `rd_data`.
  - Register 31 always selects `rd_data`, which reads 0.
- Load-use hazard: `stall_out` is high when `valid_in & valid_out & ctrl_out[MEMREAD_BIT]` and `rd_out` matches rs1 or rs2 (31 excluded).
- Capture priority at each clock edge:
  - If `flush`: `valid_out` goes to 0 and `ctrl_out` goes to 0. `stall_out` is forced to 0 while `flush` is high.
  - Else if `stall_out`: insert a bubble (`valid_out`=0, `ctrl_out`=0). The upstream stage holds the same instruction, which is recaptured on the next cycle using the MEM forward.
  - Else: capture the forwarded operands, `imm_in`, `rd_in`, `ctrl_in` and `valid_in`.
- When `valid_in`=0 the stage captures a bubble and `stall_out`=0.

## Timing
- Latency: 1 cycle from the ID inputs to the registered outputs.
- `stall_out` and the forwarding select are combinational in the same cycle. No combinational path exists from `ex_result` to `stall_out`.
- A load-use stall lasts exactly 1 cycle. After it, the load is in MEM and forwarding covers the dependency.
- Reset, asserted at any time including mid-stall: all outputs are 0 immediately, `stall_out`=0, and `valid_out`=0. Operation resumes on the first edge after deassertion.
- Simultaneous `flush` and load-use hazard: flush wins and there is no stall.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding operates as described above.
- `ID_EX_FWD_EN` undefined:
  - No forwarding; operands always come from `rd_data1`/`rd_data2`.
  - `stall_out` is high whenever a valid ID instruction matches any of the EX, MEM or WB writers.
  - A WB match stalls because the register file writes at the end of the cycle.
  - Stalls repeat until no match remains, up to 3 cycles.

## Test plan
- Reset mid-stall: assert `reset` while `stall_out`=1. All outputs read 0 within the same cycle, and `valid_out`=0 after release.
- EX forward: the EX instruction is an ADD writing X3 with `ex_result`=0x55, the next instruction reads X3 with `rd_data1`=0x11. Required: `a_out`=0x55, `stall_out`=0.
- Priority: EX, MEM and WB all target X5 with results 1, 2 and 3. Required: `b_out`=1. With EX absent: `b_out`=2. With only WB present: `b_out`=3.
- X31: all three writers target X31 with `rd_data1`=0. Required: `a_out`=0 and no stall.
- Load-use: LDUR X2 followed by ADD X4,X2,X2. Required:
  - `stall_out`=1 for exactly 1 cycle, then a bubble with `valid_out`=0.
  - The ADD is then captured with `a_out`=`b_out`=`mem_result`.
- Flush during hazard: the load-use condition and `flush`=1 occur together. Required: `stall_out`=0 and `valid_out`=0 on the next cycle.
- Without `ID_EX_FWD_EN`: a back-to-back ADD dependency. Required: `stall_out`=1 for 3 cycles, then the capture uses `rd_data1`.
